// File: rtl/store_merge_ctrl.sv
// Read-merge-write controller: splices a 32-bit store into a 512-bit line via READ/MERGE/WRITE.
// Define STORE_BYTE_MASK_EN to add the req_be byte-enable port (default build replaces the full word).
module store_merge_ctrl #(
  parameter int INDEX_W = 6
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               req_valid,
  output logic               req_ready,
  input  logic [INDEX_W-1:0] req_index,
  input  logic [3:0]         req_word,
  input  logic [31:0]        req_data,
`ifdef STORE_BYTE_MASK_EN
  input  logic [3:0]         req_be,
`endif
  output logic               arr_rd_en,
  output logic [INDEX_W-1:0] arr_rd_index,
  input  logic [511:0]       arr_rd_data,
  output logic               arr_wr_en,
  output logic [INDEX_W-1:0] arr_wr_index,
  output logic [511:0]       arr_wr_data,
  output logic               done,
  output logic [15:0]        store_cnt
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_READ  = 2'd1,
    ST_MERGE = 2'd2,
    ST_WRITE = 2'd3
  } state_t;

  state_t             state_q, state_d;
  logic [INDEX_W-1:0] index_q, index_d;
  logic [3:0]         word_q, word_d;
  logic [31:0]        data_q, data_d;
  logic [511:0]       line_q, line_d;
  logic [15:0]        cnt_q, cnt_d;
  logic [3:0]         be_s;
  logic               hs_s;

  // Bit offset of byte b in word w is {w, b, 3'b000}, so no offset can spill into a neighbour word.
  function automatic logic [511:0] merge_line(input logic [511:0] line,
                                              input logic [3:0]   word,
                                              input logic [31:0]  data,
                                              input logic [3:0]   be);
    logic [511:0] res;
    logic [8:0]   off;
    res = line;
    for (int b = 0; b < 4; b++) begin
      off = {word, b[1:0], 3'b000};
      res[off +: 8] = be[b] ? data[b*8 +: 8] : res[off +: 8];
    end
    return res;
  endfunction

  assign hs_s = req_valid && (state_q == ST_IDLE);

`ifdef STORE_BYTE_MASK_EN
  logic [3:0] be_q, be_d;

  always_comb begin
    if (hs_s) begin
      be_d = req_be;
    end else begin
      be_d = be_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      be_q <= 4'h0;
    end else begin
      be_q <= be_d;
    end
  end

  assign be_s = be_q;
`else
  assign be_s = 4'hF;
`endif

  // FSM state register plus datapath registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      index_q <= '0;
      word_q  <= 4'h0;
      data_q  <= 32'h0;
      line_q  <= 512'h0;
      cnt_q   <= 16'h0;
    end else begin
      state_q <= state_d;
      index_q <= index_d;
      word_q  <= word_d;
      data_q  <= data_d;
      line_q  <= line_d;
      cnt_q   <= cnt_d;
    end
  end

  // FSM next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  begin
        if (hs_s) begin
          state_d = ST_READ;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_READ:  state_d = ST_MERGE;
      ST_MERGE: state_d = ST_WRITE;
      ST_WRITE: state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // FSM output decode.
  always_comb begin
    req_ready = 1'b0;
    arr_rd_en = 1'b0;
    arr_wr_en = 1'b0;
    done      = 1'b0;
    case (state_q)
      ST_IDLE:  req_ready = 1'b1;
      ST_READ:  arr_rd_en = 1'b1;
      ST_MERGE: req_ready = 1'b0;
      ST_WRITE: begin
        arr_wr_en = 1'b1;
        done      = 1'b1;
      end
      default: begin
        req_ready = 1'b0;
        arr_rd_en = 1'b0;
        arr_wr_en = 1'b0;
        done      = 1'b0;
      end
    endcase
  end

  // Request capture, line merge and saturating completion count.
  always_comb begin
    if (hs_s) begin
      index_d = req_index;
      word_d  = req_word;
      data_d  = req_data;
    end else begin
      index_d = index_q;
      word_d  = word_q;
      data_d  = data_q;
    end

    if (state_q == ST_MERGE) begin
      line_d = merge_line(arr_rd_data, word_q, data_q, be_s);
    end else begin
      line_d = line_q;
    end

    if ((state_q == ST_WRITE) && (cnt_q != 16'hFFFF)) begin
      cnt_d = cnt_q + 16'd1;
    end else begin
      cnt_d = cnt_q;
    end
  end

  assign arr_rd_index = index_q;
  assign arr_wr_index = index_q;
  assign arr_wr_data  = line_q;
  assign store_cnt    = cnt_q;

endmodule

// File: tb/tb_store_merge_ctrl.sv
// Scoreboard bench for store_merge_ctrl: a behavioural line-memory model predicts each write.
module tb_store_merge_ctrl;
  localparam int IW = 6;

  logic          clk = 1'b0;
  logic          rst;
  logic          req_valid;
  logic          req_ready;
  logic [IW-1:0] req_index;
  logic [3:0]    req_word;
  logic [31:0]   req_data;
  logic [3:0]    be_drv;
`ifdef STORE_BYTE_MASK_EN
  logic [3:0]    req_be;
  assign req_be = be_drv;
`endif
  logic          arr_rd_en;
  logic [IW-1:0] arr_rd_index;
  logic [511:0]  arr_rd_data;
  logic          arr_wr_en;
  logic [IW-1:0] arr_wr_index;
  logic [511:0]  arr_wr_data;
  logic          done;
  logic [15:0]   store_cnt;

  always #5 clk = ~clk;

  store_merge_ctrl #(.INDEX_W(IW)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_index(req_index), .req_word(req_word), .req_data(req_data),
`ifdef STORE_BYTE_MASK_EN
    .req_be(req_be),
`endif
    .arr_rd_en(arr_rd_en), .arr_rd_index(arr_rd_index), .arr_rd_data(arr_rd_data),
    .arr_wr_en(arr_wr_en), .arr_wr_index(arr_wr_index), .arr_wr_data(arr_wr_data),
    .done(done), .store_cnt(store_cnt)
  );

  typedef struct {
    logic [IW-1:0] idx;
    logic [511:0]  line;
    int            hs_cyc;
  } exp_t;

  exp_t         sb_q[$];
  logic [511:0] arr[64];
  logic [511:0] model_mem[64];
  logic [15:0]  model_cnt = 16'h0;
  int           n_chk = 0;
  int           n_fail = 0;
  int           cyc = 0;
  int           last_hs = -100;
  int           busy_until = -1;
  logic [IW-1:0] hs_idx = '0;
  bit           burst_on = 1'b0;
  int           burst_n = 0;
  bit           rd_pend = 1'b0;
  logic [IW-1:0] rd_pidx = '0;

  task automatic chk(input string nm, input logic [511:0] act, input logic [511:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic logic [511:0] model_store(input logic [511:0] line, input int word,
                                               input logic [31:0] data, input logic [3:0] be);
    logic [511:0] res = line;
    for (int b = 0; b < 4; b++)
      if (be[b]) res[word*32 + b*8 +: 8] = data[b*8 +: 8];
    return res;
  endfunction

  always @(posedge clk) cyc <= cyc + 1;

  // Array responder: read data only valid in the cycle after the strobe
  always @(negedge clk) begin
    rd_pend = arr_rd_en;
    rd_pidx = arr_rd_index;
    if (arr_wr_en) arr[arr_wr_index] = arr_wr_data;
  end

  always @(posedge clk) begin
    #1;
    if (rd_pend) arr_rd_data = arr[rd_pidx];
    else arr_rd_data = {16{$urandom()}};
  end

  // Monitor / scoreboard
  always @(negedge clk) begin
    logic [3:0] be_now;
    exp_t e;
    if (rst) begin
      sb_q.delete();
      model_cnt = 16'h0;
      busy_until = cyc;
    end else begin
      chk("req_ready", 512'(req_ready), 512'(cyc > busy_until));
      if (req_valid && req_ready) begin
`ifdef STORE_BYTE_MASK_EN
        be_now = be_drv;
`else
        be_now = 4'hF;
`endif
        e.idx = req_index;
        e.line = model_store(model_mem[req_index], int'(req_word), req_data, be_now);
        e.hs_cyc = cyc;
        sb_q.push_back(e);
        if (burst_on) begin
          if (burst_n > 0) chk("hs_spacing", 512'(cyc - last_hs), 512'(4));
          burst_n++;
        end
        last_hs = cyc;
        hs_idx = req_index;
        busy_until = cyc + 3;
      end
      if (arr_rd_en) begin
        chk("rd_cycle", 512'(cyc), 512'(last_hs + 1));
        chk("rd_index", 512'(arr_rd_index), 512'(hs_idx));
      end
      if (arr_wr_en || done) begin
        chk("write_expected", 512'(sb_q.size() != 0), 512'(1));
        if (sb_q.size() != 0) begin
          e = sb_q.pop_front();
          chk("wr_done_pair", 512'({arr_wr_en, done}), 512'(2'b11));
          chk("wr_index", 512'(arr_wr_index), 512'(e.idx));
          chk("wr_data", arr_wr_data, e.line);
          chk("wr_cycle", 512'(cyc), 512'(e.hs_cyc + 3));
          chk("store_cnt_at_done", 512'(store_cnt), 512'(model_cnt));
          model_mem[e.idx] = e.line;
          if (model_cnt != 16'hFFFF) model_cnt = model_cnt + 16'd1;
        end
      end
    end
  end

  task automatic scramble();
    req_index = IW'($urandom());
    req_word  = 4'($urandom());
    req_data  = $urandom();
    be_drv    = 4'($urandom());
  endtask

  task automatic do_store(input logic [IW-1:0] idx, input logic [3:0] w,
                          input logic [31:0] d, input logic [3:0] be);
    bit ok = 1'b0;
    @(posedge clk); #1;
    req_valid = 1'b1; req_index = idx; req_word = w; req_data = d; be_drv = be;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (req_ready) begin ok = 1'b1; break; end
    end
    chk("handshake_seen", 512'(ok), 512'(1));
    @(posedge clk); #1;
    req_valid = 1'b0;
    scramble();
  endtask

  task automatic wait_idle();
    bit ok = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (sb_q.size() == 0 && req_ready) begin ok = 1'b1; break; end
    end
    chk("idle_reached", 512'(ok), 512'(1));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int pulses;
    for (int i = 0; i < 64; i++) begin
      arr[i] = {16{$urandom()}} ^ {512'(i)};
      model_mem[i] = arr[i];
    end
    rst = 1'b1; req_valid = 1'b0; req_index = '0; req_word = 4'h0; req_data = 32'h0;
    be_drv = 4'hF; arr_rd_data = 512'h0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("reset_ready", 512'(req_ready), 512'(1));
    chk("reset_rd_en", 512'(arr_rd_en), 512'(0));
    chk("reset_wr_en", 512'(arr_wr_en), 512'(0));
    chk("reset_done", 512'(done), 512'(0));
    chk("reset_cnt", 512'(store_cnt), 512'(0));
    chk("reset_line", arr_wr_data, 512'h0);

    // First store into a zero line
    arr[5] = 512'h0; model_mem[5] = 512'h0;
    do_store(6'd5, 4'd0, 32'hDEADBEEF, 4'hF);
    wait_idle();
    chk("first_line", arr[5], {480'h0, 32'hDEADBEEF});
    chk("first_cnt", 512'(store_cnt), 512'(1));

    // Top word of an all-ones line
    arr[7] = {512{1'b1}}; model_mem[7] = {512{1'b1}};
    do_store(6'd7, 4'd15, 32'h0, 4'hF);
    wait_idle();
    chk("top_word_line", arr[7], {32'h0, {480{1'b1}}});

`ifdef STORE_BYTE_MASK_EN
    arr[9] = 512'h0; model_mem[9] = 512'h0;
    do_store(6'd9, 4'd3, 32'hAABBCCDD, 4'b0101);
    wait_idle();
    chk("byte_mask_word", 512'(arr[9][127:96]), 512'(32'h00BB00DD));
    do_store(6'd9, 4'd3, 32'h11223344, 4'b0000);
    wait_idle();
    chk("byte_mask_none", 512'(arr[9][127:96]), 512'(32'h00BB00DD));
`endif

    // Back-to-back stores to one line must see each other
    do_store(6'd2, 4'd4, 32'h12345678, 4'hF);
    do_store(6'd2, 4'd5, 32'h9ABCDEF0, 4'hF);
    wait_idle();

    for (int n = 0; n < 40; n++) begin
      do_store(IW'($urandom_range(0, 7)), 4'($urandom()), $urandom(), 4'($urandom()));
      repeat ($urandom_range(0, 3)) @(posedge clk);
    end
    wait_idle();

    // Continuous request: one store per four cycles
    @(posedge clk); #1;
    burst_on = 1'b1; burst_n = 0;
    for (int i = 0; i < 16; i++) begin
      scramble();
      req_valid = 1'b1;
      @(posedge clk); #1;
    end
    req_valid = 1'b0;
    burst_on = 1'b0;
    chk("burst_count", 512'(burst_n), 512'(4));
    wait_idle();

    // Reset in MERGE abandons the store
    do_store(6'd11, 4'd6, 32'hCAFEF00D, 4'hF);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("abort_ready", 512'(req_ready), 512'(1));
    chk("abort_cnt", 512'(store_cnt), 512'(0));
    chk("abort_line", arr_wr_data, 512'h0);
    pulses = 0;
    repeat (6) begin
      @(negedge clk);
      pulses += int'(arr_wr_en) + int'(done);
    end
    chk("abort_no_write", 512'(pulses), 512'(0));
    chk("abort_cnt_after", 512'(store_cnt), 512'(0));

    do_store(6'd11, 4'd1, 32'h0BADC0DE, 4'hF);
    wait_idle();

    // Saturation near the top of the count range
    dut.cnt_q = 16'hFFFD;
    model_cnt = 16'hFFFD;
    for (int n = 0; n < 3; n++)
      do_store(IW'($urandom_range(0, 63)), 4'($urandom()), $urandom(), 4'hF);
    wait_idle();
    chk("cnt_saturated", 512'(store_cnt), 512'(16'hFFFF));

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
